// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART controller slice (arbiter, uart_tx, uart_rx top).
package uart_ctrl_pkg;

  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned CLK_HZ             = 50_000_000;
  localparam int unsigned BAUD               = 115_200;
  localparam int unsigned CLKS_PER_BIT       = CLK_HZ / BAUD;
  localparam int unsigned FRAME_CYCLES       = 10 * CLKS_PER_BIT;
  localparam int unsigned TX_TIMEOUT_DEFAULT = 8192;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after the pointer.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         grant_oh_c_o,
  output logic [$clog2(N_REQ)-1:0] grant_idx_c_o,
  output logic                     any_valid_c_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic        found;
  int unsigned pos;

  always_comb begin
    grant_oh_c_o  = '0;
    grant_idx_c_o = '0;
    found         = 1'b0;
    pos           = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = (32'(ptr_i) + k) % N_REQ;
      if (!found && req_valid_i[pos]) begin
        found              = 1'b1;
        grant_oh_c_o[pos]  = 1'b1;
        grant_idx_c_o      = IDX_W'(pos);
      end
    end
    any_valid_c_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among N_REQ byte producers, with a
// done-pulse watchdog and an optional idle gap between bytes.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = TX_TIMEOUT_DEFAULT,
  parameter int unsigned GAP_CYCLES     = 0
) (
  input  logic                      MAX10_CLK1_50,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [BYTE_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      tx_dv,
  output logic [BYTE_W-1:0]         tx_byte,
  input  logic                      tx_active,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      timeout_err
);

  localparam int unsigned GNT_W    = $clog2(N_REQ);
  localparam int unsigned WD_W     = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GAP_W    = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
  localparam arb_state_e  DONE_NEXT = (GAP_CYCLES == 0) ? IDLE : GAP;

  arb_state_e        state_q;
  logic [N_REQ-1:0]  req_ready_q;
  logic              tx_dv_q;
  logic [BYTE_W-1:0] tx_byte_q;
  logic [GNT_W-1:0]  grant_id_q;
  logic              timeout_err_q;
  logic              busy_q;
  logic [WD_W-1:0]   wd_q;
  logic [GAP_W-1:0]  gap_q;
  logic [GNT_W-1:0]  ptr_q;

  logic [N_REQ-1:0]  grant_oh_c;
  logic [GNT_W-1:0]  grant_idx_c;
  logic              any_valid_c;
  logic [BYTE_W-1:0] tx_byte_d;
  logic [GNT_W-1:0]  ptr_d;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req_valid_i   (req_valid),
    .ptr_i         (ptr_q),
    .grant_oh_c_o  (grant_oh_c),
    .grant_idx_c_o (grant_idx_c),
    .any_valid_c_o (any_valid_c)
  );

  // Winner's byte and the pointer slot just past the winner.
  always_comb begin
    tx_byte_d = req_data[grant_idx_c*BYTE_W +: BYTE_W];
    ptr_d     = (grant_idx_c == GNT_W'(N_REQ - 1)) ? '0 : grant_idx_c + GNT_W'(1);
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      state_q       <= IDLE;
      req_ready_q   <= '0;
      tx_dv_q       <= 1'b0;
      tx_byte_q     <= '0;
      grant_id_q    <= '0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      wd_q          <= '0;
      gap_q         <= '0;
      ptr_q         <= '0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A frame still in flight (e.g. after reset) blocks arbitration.
          if (!tx_active && any_valid_c) begin
            tx_byte_q   <= tx_byte_d;
            grant_id_q  <= grant_idx_c;
            req_ready_q <= grant_oh_c;
            tx_dv_q     <= 1'b1;
            ptr_q       <= ptr_d;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          req_ready_q <= '0;
          tx_dv_q     <= 1'b0;
          wd_q        <= '0;
          state_q     <= WAIT_DONE;
        end
        WAIT_DONE: begin
          wd_q <= wd_q + WD_W'(1);
          // tx_done takes precedence over a coincident watchdog expiry.
          if (tx_done || (wd_q == WD_W'(TIMEOUT_CYCLES - 1))) begin
            timeout_err_q <= !tx_done;
            gap_q         <= '0;
            busy_q        <= (DONE_NEXT != IDLE);
            state_q       <= DONE_NEXT;
          end
        end
        GAP: begin
          if (gap_q == GAP_W'(GAP_LAST)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_dv       = tx_dv_q;
  assign tx_byte     = tx_byte_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: randomized requesters, a stub transmitter
// and a window-based reference model feeding a per-cycle expectation queue.
module tb_uart_tx_arbiter;

  localparam int unsigned N       = 4;
  localparam int unsigned T       = 16;
  localparam int unsigned G       = 3;
  localparam int          END_CYC = 2400;
  localparam int          MAX_CYC = 6000;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_dv;
  logic [7:0]     tx_byte;
  logic           tx_active;
  logic           tx_done;
  logic           busy;
  logic [1:0]     grant_id;
  logic           timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (T),
    .GAP_CYCLES     (G)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .tx_dv         (tx_dv),
    .tx_byte       (tx_byte),
    .tx_active     (tx_active),
    .tx_done       (tx_done),
    .busy          (busy),
    .grant_id      (grant_id),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    int         cyc;
    bit         busy;
    bit         dv;
    logic [N-1:0] ready;
    bit         terr;
    logic [7:0] bval;
    int         gid;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] recv_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  // Monitor: pops the expectation for the current cycle and compares every output.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL stale_expectation cycle %0d: got entry for %0d expected %0d", cyc, exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("busy",        64'(busy),        64'(e.busy));
      chk("tx_dv",       64'(tx_dv),       64'(e.dv));
      chk("req_ready",   64'(req_ready),   64'(e.ready));
      chk("timeout_err", 64'(timeout_err), 64'(e.terr));
      chk("tx_byte",     64'(tx_byte),     64'(e.bval));
      chk("grant_id",    64'(grant_id),    64'(e.gid));
    end
  end

  // Reference model state: grant windows expressed as cycle numbers.
  int         free_from, s_cyc, ptr, last_id, win;
  bit         waiting, gnt, terr, found;
  logic [7:0] last_b;
  // Stub transmitter state.
  int         active_until, done_at, mode, flen;
  bit         poke, reset_wanted, finished;
  exp_t       e;
  logic [N-1:0] oh;

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; tx_active = 1'b0; tx_done = 1'b0;
    free_from = 0; s_cyc = 0; ptr = 0; last_id = 0; last_b = '0; waiting = 1'b0;
    active_until = 0; done_at = 0; reset_wanted = 1'b0; finished = 1'b0;
    while (!finished) begin
      @(posedge clk); #1;
      cyc++;

      // Requesters retire a byte on their accept pulse.
      for (int i = 0; i < N; i++)
        if (req_ready[i] === 1'b1) req_valid[i] = 1'b0;

      // Stub transmitter: start a frame on tx_dv with a randomly chosen ending.
      poke = 1'b0;
      if (tx_dv === 1'b1) begin
        recv_q.push_back(tx_byte);
        mode = (cyc < 200) ? 0 : int'($urandom_range(0, 9));
        if (mode <= 6) begin
          flen = int'($urandom_range(2, 12));
          active_until = cyc + flen - 1;
          done_at      = cyc + flen;
        end else if (mode <= 8) begin
          active_until = cyc + T + 4;
          done_at      = 0;
        end else begin
          active_until = cyc + T - 1;
          done_at      = cyc + T;
        end
        if (cyc >= 200 && $urandom_range(0, 3) == 0) poke = 1'b1;
      end
      if (cyc >= 200 && cyc < END_CYC && cyc > active_until && cyc != done_at &&
          $urandom_range(0, 9) == 0) poke = 1'b1;
      tx_active = (cyc <= active_until);
      tx_done   = (cyc == done_at) || poke;

      // Occasional reset while waiting on a live frame.
      if (cyc == 120 || cyc == 700 || cyc == 1400 || cyc == 1900) reset_wanted = 1'b1;
      rst = 1'b0;
      if (cyc < 4) rst = 1'b1;
      else if (reset_wanted && waiting && cyc >= s_cyc + 2 && tx_active) begin
        rst = 1'b1;
        reset_wanted = 1'b0;
      end

      // Requester stimulus by phase.
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if (cyc == 4 && i == 0) begin
            req_valid[i] = 1'b1;
            req_data[i*8 +: 8] = 8'h55;
          end else if (cyc >= 40 && cyc < 200) begin
            req_valid[i] = 1'b1;
            req_data[i*8 +: 8] = 8'(16 + 17 * i);
          end else if (cyc >= 200 && cyc < END_CYC && $urandom_range(0, 99) < 30) begin
            req_valid[i] = 1'b1;
            req_data[i*8 +: 8] = 8'($urandom);
          end
        end
      end

      // Reference model for this cycle; expectations apply to the next cycle.
      gnt = 1'b0; terr = 1'b0;
      if (rst) begin
        ptr = 0; waiting = 1'b0; free_from = cyc + 1; last_b = '0; last_id = 0;
      end else if (!waiting) begin
        if (cyc >= free_from && !tx_active && req_valid != '0) begin
          found = 1'b0; win = 0;
          for (int k = 0; k < N; k++)
            if (!found && req_valid[(ptr + k) % N]) begin
              found = 1'b1;
              win = (ptr + k) % N;
            end
          last_id = win;
          last_b  = req_data[win*8 +: 8];
          ptr     = (win + 1) % N;
          waiting = 1'b1;
          s_cyc   = cyc + 1;
          gnt     = 1'b1;
          sent_q.push_back(last_b);
        end
      end else if (cyc > s_cyc) begin
        if (tx_done) begin
          waiting = 1'b0; free_from = cyc + 1 + G;
        end else if (cyc == s_cyc + T) begin
          waiting = 1'b0; free_from = cyc + 1 + G; terr = 1'b1;
        end
      end
      oh = '0;
      if (gnt) oh[last_id] = 1'b1;
      e.cyc = cyc + 1; e.busy = waiting || (cyc + 1 < free_from); e.dv = gnt;
      e.ready = oh; e.terr = terr; e.bval = last_b; e.gid = last_id;
      exp_q.push_back(e);

      if (cyc >= END_CYC && !waiting && req_valid == '0 && cyc >= free_from + 2) finished = 1'b1;
      if (cyc >= MAX_CYC) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout cycle %0d: got pending %0b expected 0", cyc, req_valid);
        finished = 1'b1;
      end
    end

    repeat (2) @(negedge clk);
    chk("byte_count", 64'(recv_q.size()), 64'(sent_q.size()));
    for (int i = 0; i < sent_q.size() && i < recv_q.size(); i++)
      chk("byte_order", 64'(recv_q[i]), 64'(sent_q[i]));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
